// File: rtl/riscv_trace_capture_if.sv
// Trace sample bus and valid/ready drain port of riscv_trace_capture.
// TRACE_TIMESTAMP_EN adds a 16-bit timestamp prefix to rd_data (56 -> 72 bits).
interface riscv_trace_capture_if;
`ifdef TRACE_TIMESTAMP_EN
    localparam int ENTRY_W = 72;
`else
    localparam int ENTRY_W = 56;
`endif

    logic               cap_en;
    logic [31:0]        wb_data;
    logic [6:0]         opcode_in;
    logic [1:0]         aluop_in;
    logic [6:0]         funct7_in;
    logic [2:0]         funct3_in;
    logic [4:0]         operation_in;
    logic               rd_ready;
    logic               rd_valid;
    logic [ENTRY_W-1:0] rd_data;

    modport master (
        output cap_en, wb_data, opcode_in, aluop_in, funct7_in, funct3_in, operation_in, rd_ready,
        input  rd_valid, rd_data
    );

    modport slave (
        input  cap_en, wb_data, opcode_in, aluop_in, funct7_in, funct3_in, operation_in, rd_ready,
        output rd_valid, rd_data
    );
endinterface

// File: rtl/riscv_trace_capture.sv
// Circular trace buffer for the core's debug outputs: capture, opcode trigger, post window, drain.
// Optional TRACE_TIMESTAMP_EN prepends a 16-bit cycle stamp; rd_data carries all captured fields.
module riscv_trace_capture #(
    parameter int DEPTH        = 16,
    parameter int POST_SAMPLES = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     arm,
    input  logic                     clear,
    input  logic [6:0]               trig_opcode,
    input  logic                     trig_force,
    riscv_trace_capture_if.slave     trc,
    output logic [1:0]               state_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     wrapped_o
);
    localparam int AW     = $clog2(DEPTH);
    localparam int DATA_W = 56;
`ifdef TRACE_TIMESTAMP_EN
    localparam int ENTRY_W = DATA_W + 16;
`else
    localparam int ENTRY_W = DATA_W;
`endif
    localparam logic [AW:0]   FULL      = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] POST_INIT = AW'(POST_SAMPLES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      post_cnt_q, post_cnt_d;
    logic [AW:0]        count_q, count_d;
    logic               wrapped_q, wrapped_d;
    logic               wr_en;
    logic               trigger;
    logic               restart;
    logic               rd_fire;
    logic [AW-1:0]      rd_ptr;
    logic [DATA_W-1:0]  sample;
    logic [ENTRY_W-1:0] entry;
    logic [ENTRY_W-1:0] mem [DEPTH];

    assign sample = {trc.wb_data, trc.opcode_in, trc.aluop_in,
                     trc.funct7_in, trc.funct3_in, trc.operation_in};

`ifdef TRACE_TIMESTAMP_EN
    logic [15:0] ts_q, ts_d;
    assign entry = {ts_q, sample};
`else
    assign entry = sample;
`endif

    assign trigger = trc.cap_en & (trig_force | (trc.opcode_in == trig_opcode));
    assign restart = arm & (state_q != DONE);
    // Oldest unread entry sits count entries behind the write pointer.
    assign rd_ptr       = wr_ptr_q - count_q[AW-1:0];
    assign trc.rd_valid = (state_q == DONE) && (count_q != '0);
    assign trc.rd_data  = trc.rd_valid ? mem[rd_ptr] : '0;
    assign rd_fire      = trc.rd_valid & trc.rd_ready;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        post_cnt_d = post_cnt_q;
        wrapped_d  = wrapped_q;
        wr_en      = 1'b0;

        if (clear) begin
            state_d    = IDLE;
            wr_ptr_d   = '0;
            count_d    = '0;
            post_cnt_d = '0;
            wrapped_d  = 1'b0;
        end else if (restart) begin
            state_d    = ARMED;
            wr_ptr_d   = '0;
            count_d    = '0;
            post_cnt_d = '0;
            wrapped_d  = 1'b0;
        end else begin
            unique case (state_q)
                ARMED: begin
                    if (trc.cap_en) begin
                        wr_en = 1'b1;
                        if (trigger) begin
                            if (POST_SAMPLES == 0) begin
                                state_d = DONE;
                            end else begin
                                state_d    = POST;
                                post_cnt_d = POST_INIT;
                            end
                        end
                    end
                end
                POST: begin
                    if (trc.cap_en) begin
                        wr_en      = 1'b1;
                        post_cnt_d = post_cnt_q - 1'b1;
                        if (post_cnt_q == AW'(1)) state_d = DONE;
                    end
                end
                DONE: begin
                    if (rd_fire) begin
                        count_d = count_q - 1'b1;
                        if (count_q == (AW+1)'(1)) state_d = IDLE;
                    end
                end
                default: ;
            endcase

            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                if (count_q == FULL) wrapped_d = 1'b1;
                else                 count_d   = count_q + 1'b1;
            end
        end
    end

`ifdef TRACE_TIMESTAMP_EN
    assign ts_d = (clear || restart) ? 16'h0000 : ts_q + 16'h0001;
`endif

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            post_cnt_q <= '0;
            wrapped_q  <= 1'b0;
`ifdef TRACE_TIMESTAMP_EN
            ts_q       <= '0;
`endif
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            post_cnt_q <= post_cnt_d;
            wrapped_q  <= wrapped_d;
`ifdef TRACE_TIMESTAMP_EN
            ts_q       <= ts_d;
`endif
        end
    end

    // NOTE: storage is not reset; rd_valid/count gate every read so stale contents never escape.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= entry;
    end

    assign state_o   = state_q;
    assign count_o   = count_q;
    assign wrapped_o = wrapped_q;
endmodule
